// File: rtl/snow64_mem_access_arbiter_if.sv
// rtl/snow64_mem_access_arbiter_if.sv - cache/memory signal bundle for the memory access arbiter
//
// Groups the icache, dcache and external memory port signals that meet at the
// arbiter.
//   slave  : arbiter side (samples requests and memory responses, drives
//            completions and the memory request).
//   master : environment side (caches plus memory), the mirror of slave.
// Parameters: ADDR_WIDTH (line address width), LINE_WIDTH (cache line bits).

interface snow64_mem_access_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = 256
);
  // icache line-read channel
  logic                  ic_req;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_valid;
  logic [LINE_WIDTH-1:0] ic_data;
  logic                  ic_err;

  // dcache line-fill / write-back channel
  logic                  dc_req;
  logic                  dc_we;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [LINE_WIDTH-1:0] dc_wdata;
  logic                  dc_valid;
  logic [LINE_WIDTH-1:0] dc_data;
  logic                  dc_err;

  // external memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  mem_valid;
  logic [LINE_WIDTH-1:0] mem_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_valid, mem_rdata,
    output ic_valid, ic_data, ic_err, dc_valid, dc_data, dc_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_valid, mem_rdata,
    input  ic_valid, ic_data, ic_err, dc_valid, dc_data, dc_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/snow64_mem_access_arbiter.sv
// rtl/snow64_mem_access_arbiter.sv - round-robin icache/dcache arbiter for the single memory port
//
// Grants level-held line requests from the icache and dcache, alternating
// when both are pending (first contested grant goes to the icache). One
// memory transaction is in flight at a time; its completion is returned to
// the requester as a one-cycle valid pulse with the read line (0 for a
// dcache write-back). Every output is registered and resets to 0.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : snow64_mem_access_arbiter_if.slave (icache, dcache, memory port)
//
// Optional feature: define SNOW64_MEM_ARBITER_TIMEOUT_EN to abort a memory
// transaction after TIMEOUT_CYCLES busy cycles without a response; the
// requester then sees valid with err=1 and a zero line. Without it the
// arbiter waits indefinitely and ic_err/dc_err stay 0.

module snow64_mem_access_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  snow64_mem_access_arbiter_if.slave    bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IC = 2'd1;
  localparam logic [1:0] ST_BUSY_DC = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

  localparam logic [LINE_WIDTH-1:0] ZERO_LINE = {LINE_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

  logic [1:0] state;
  logic       last_grant;
  logic       grant_ic;
  logic       grant_dc;
  logic       timeout_hit;

  // On contention the requester that was not served last wins.
  always_comb begin
    grant_ic = bus.ic_req && (!bus.dc_req || (last_grant == GRANT_DC));
    grant_dc = bus.dc_req && (!bus.ic_req || (last_grant == GRANT_IC));
  end

`ifdef SNOW64_MEM_ARBITER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            busy;
  logic [TO_W-1:0] to_cnt;

  assign busy = (state == ST_BUSY_IC) || (state == ST_BUSY_DC);

  // Held at zero outside BUSY so every transaction starts from a clean count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!busy) begin
      to_cnt <= '0;
    end else if (!bus.mem_valid) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires on the edge that would make the count reach TIMEOUT_CYCLES; a
  // response on that same edge takes priority.
  assign timeout_hit = busy && !bus.mem_valid &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_grant    <= GRANT_DC;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= ZERO_ADDR;
      bus.mem_wdata <= ZERO_LINE;
      bus.ic_valid  <= 1'b0;
      bus.ic_data   <= ZERO_LINE;
      bus.ic_err    <= 1'b0;
      bus.dc_valid  <= 1'b0;
      bus.dc_data   <= ZERO_LINE;
      bus.dc_err    <= 1'b0;
    end else begin
      // Completion pulses last exactly the DONE cycle.
      bus.ic_valid <= 1'b0;
      bus.dc_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          // mem_valid arriving here belongs to an aborted transaction.
          if (grant_ic) begin
            bus.mem_addr <= bus.ic_addr;
            bus.mem_we   <= 1'b0;
            bus.mem_req  <= 1'b1;
            last_grant   <= GRANT_IC;
            state        <= ST_BUSY_IC;
          end else if (grant_dc) begin
            bus.mem_addr  <= bus.dc_addr;
            bus.mem_we    <= bus.dc_we;
            bus.mem_wdata <= bus.dc_wdata;
            bus.mem_req   <= 1'b1;
            last_grant    <= GRANT_DC;
            state         <= ST_BUSY_DC;
          end
        end

        ST_BUSY_IC: begin
          if (bus.mem_valid || timeout_hit) begin
            bus.mem_req  <= 1'b0;
            bus.ic_valid <= 1'b1;
            bus.ic_err   <= timeout_hit;
            bus.ic_data  <= bus.mem_valid ? bus.mem_rdata : ZERO_LINE;
            state        <= ST_DONE;
          end
        end

        ST_BUSY_DC: begin
          if (bus.mem_valid || timeout_hit) begin
            bus.mem_req  <= 1'b0;
            bus.dc_valid <= 1'b1;
            bus.dc_err   <= timeout_hit;
            bus.dc_data  <= (bus.mem_valid && !bus.mem_we) ? bus.mem_rdata : ZERO_LINE;
            state        <= ST_DONE;
          end
        end

        // Requests are deliberately not sampled here so a requester still
        // holding req while it sees valid is not granted a second time.
        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
